// File: rtl/uart_tx_pkg.sv
// Shared UART constants and types (transmit side of the AZPR I/O UART).
// Bit timing here must stay in step with the receiver's sampling divider.
package uart_tx_pkg;

    localparam int UART_DIV_RATE  = 260;
    localparam int UART_DIV_CNT_W = 9;

    typedef enum logic {
        UART_STATE_IDLE = 1'b0,
        UART_STATE_TX   = 1'b1
    } uart_state_e;

    localparam int              UART_BIT_CNT_W     = 4;
    localparam logic [3:0]      UART_BIT_CNT_START = 4'd0;
    localparam logic [3:0]      UART_BIT_CNT_MSB   = 4'd8;
    localparam logic [3:0]      UART_BIT_CNT_STOP  = 4'd9;

    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;

    localparam int UART_TX_FIFO_DEPTH = 4;

    // Bits needed to hold the value v (at least 1).
    function automatic int bits_for(input int unsigned v);
        int n;
        n = 1;
        while ((v >> n) != 0) n++;
        return n;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer: synchronous FIFO with full/empty flags and an
// overflow pulse for pushes dropped while full.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_ovf
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_ovf;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_data    = r_mem[r_rd_ptr];
    assign o_ovf     = r_ovf;
    // A push against a full FIFO is dropped even if a pop frees a slot this cycle.
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_ovf <= i_push && o_full;
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: FIFO-fed FSM, bit divider and shift register.
// Queued bytes go out back-to-back with no idle gap between frames.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DIV_RATE   = UART_DIV_RATE,
    parameter int FIFO_DEPTH = UART_TX_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       tx_busy,
    output logic       tx_end,
    output logic       tx_ovf,
    output logic       tx
);

    localparam int               DIV_W      = bits_for(DIV_RATE);
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DIV_RATE);

    uart_state_e               r_state;
    logic [DIV_W-1:0]          r_div_cnt;
    logic [UART_BIT_CNT_W-1:0] r_bit_cnt;
    logic [7:0]                r_sh;
    logic                      r_tx;
    logic                      r_busy;
    logic                      r_end;

    logic [7:0] w_head;
    logic       w_empty;
    logic       w_frame_done;
    logic       w_pop;

    assign w_frame_done = (r_state == UART_STATE_TX) && (r_div_cnt == '0) &&
                          (r_bit_cnt == UART_BIT_CNT_STOP);
    assign w_pop        = !w_empty && ((r_state == UART_STATE_IDLE) || w_frame_done);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (tx_start),
        .i_data  (tx_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (tx_full),
        .o_empty (w_empty),
        .o_ovf   (tx_ovf)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= UART_STATE_IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= UART_BIT_CNT_START;
            r_sh      <= '0;
            r_tx      <= UART_STOP_BIT;
            r_busy    <= 1'b0;
            r_end     <= 1'b0;
        end else begin
            r_end <= 1'b0;
            case (r_state)
                UART_STATE_IDLE: begin
                    if (w_pop) begin
                        r_sh      <= w_head;
                        r_tx      <= UART_START_BIT;
                        r_div_cnt <= DIV_RELOAD;
                        r_bit_cnt <= UART_BIT_CNT_START;
                        r_busy    <= 1'b1;
                        r_state   <= UART_STATE_TX;
                    end
                end
                UART_STATE_TX: begin
                    if (r_div_cnt != '0) begin
                        r_div_cnt <= r_div_cnt - 1'b1;
                    end else if (r_bit_cnt == UART_BIT_CNT_STOP) begin
                        r_end <= 1'b1;
                        // Next byte's start bit begins right where the stop bit ends.
                        if (w_pop) begin
                            r_sh      <= w_head;
                            r_tx      <= UART_START_BIT;
                            r_div_cnt <= DIV_RELOAD;
                            r_bit_cnt <= UART_BIT_CNT_START;
                        end else begin
                            r_tx    <= UART_STOP_BIT;
                            r_busy  <= 1'b0;
                            r_state <= UART_STATE_IDLE;
                        end
                    end else if (r_bit_cnt == UART_BIT_CNT_MSB) begin
                        r_tx      <= UART_STOP_BIT;
                        r_bit_cnt <= UART_BIT_CNT_STOP;
                        r_div_cnt <= DIV_RELOAD;
                    end else begin
                        r_tx      <= r_sh[0];
                        r_sh      <= {1'b0, r_sh[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_div_cnt <= DIV_RELOAD;
                    end
                end
                default: r_state <= UART_STATE_IDLE;
            endcase
        end
    end

    assign tx       = r_tx;
    assign tx_busy  = r_busy;
    assign tx_end   = r_end;
    assign tx_empty = w_empty;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at DIV_RATE=4 (5 clocks/bit, 50 clocks/frame).
// Outputs are logged every falling edge, indexed by rising-edge count.
module tb_uart_tx;

    localparam int LOGN = 4096;

    logic       clk;
    logic       reset;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_full, tx_empty, tx_busy, tx_end, tx_ovf, tx;

    uart_tx #(
        .DIV_RATE   (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_full  (tx_full),
        .tx_empty (tx_empty),
        .tx_busy  (tx_busy),
        .tx_end   (tx_end),
        .tx_ovf   (tx_ovf),
        .tx       (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic tx_log    [LOGN];
    logic busy_log  [LOGN];
    logic end_log   [LOGN];
    logic ovf_log   [LOGN];
    logic full_log  [LOGN];
    logic empty_log [LOGN];

    always @(negedge clk) begin
        if (cyc < LOGN) begin
            tx_log[cyc]    <= tx;
            busy_log[cyc]  <= tx_busy;
            end_log[cyc]   <= tx_end;
            ovf_log[cyc]   <= tx_ovf;
            full_log[cyc]  <= tx_full;
            empty_log[cyc] <= tx_empty;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;   // line[0] = start bit ... line[9] = stop bit
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic sample(input int sel, input int i);
        if (i < 0 || i >= LOGN) return 1'bx;
        case (sel)
            0:       return tx_log[i];
            1:       return busy_log[i];
            2:       return end_log[i];
            3:       return ovf_log[i];
            4:       return full_log[i];
            default: return empty_log[i];
        endcase
    endfunction

    function automatic logic [31:0] ones(input int sel, input int a, input int b);
        logic [31:0] c;
        c = '0;
        for (int i = a; i <= b; i++) if (sample(sel, i) === 1'b1) c++;
        return c;
    endfunction

    task automatic check_frame(input string tag, input int start, input logic [9:0] line);
        logic [4:0] got;
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < 5; k++) got[k] = sample(0, start + 5 * b + k);
            check($sformatf("%s bit%0d", tag, b), {27'd0, got}, {27'd0, {5{line[b]}}});
        end
    endtask

    task automatic push_bytes(input logic [7:0] b [8], input int n, output int first);
        first = cyc;
        for (int i = 0; i < n; i++) begin
            tx_start = 1'b1;
            tx_data  = b[i];
            @(posedge clk);
            #1;
            if (i == 0) first = cyc;
        end
        tx_start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pb [8];
        int n0, r0;

        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h3C, 10'b1001111000};
        vecs[4] = '{8'h11, 10'b1000100010};
        vecs[5] = '{8'h22, 10'b1001000100};
        vecs[6] = '{8'h33, 10'b1001100110};
        vecs[7] = '{8'h44, 10'b1010001000};
        vecs[8] = '{8'h55, 10'b1010101010};
        for (int i = 0; i < 8; i++) pb[i] = '0;

        reset = 1'b0; tx_start = 1'b0; tx_data = '0;
        tick(3);
        check("rst tx",    {31'd0, tx},       32'd1);
        check("rst busy",  {31'd0, tx_busy},  32'd0);
        check("rst empty", {31'd0, tx_empty}, 32'd1);
        check("rst full",  {31'd0, tx_full},  32'd0);
        check("rst end",   {31'd0, tx_end},   32'd0);
        check("rst ovf",   {31'd0, tx_ovf},   32'd0);

        reset = 1'b1;
        r0 = cyc;
        tick(101);
        check("idle tx high",   ones(0, r0 + 1, r0 + 100), 32'd100);
        check("idle empty",     ones(5, r0 + 1, r0 + 100), 32'd100);
        check("idle busy low",  ones(1, r0 + 1, r0 + 100), 32'd0);

        // Single frames from the vector table.
        for (int v = 0; v < 4; v++) begin
            pb[0] = vecs[v].data;
            push_bytes(pb, 1, n0);
            tick(62);
            check($sformatf("v%0d tx before", v), {31'd0, sample(0, n0)}, 32'd1);
            check_frame($sformatf("v%0d", v), n0 + 1, vecs[v].line);
            check($sformatf("v%0d end at N+51", v), {31'd0, sample(2, n0 + 51)}, 32'd1);
            check($sformatf("v%0d end pulses", v), ones(2, n0, n0 + 61), 32'd1);
            check($sformatf("v%0d busy len", v), ones(1, n0 + 1, n0 + 50), 32'd50);
            check($sformatf("v%0d busy off", v), {31'd0, sample(1, n0 + 51)}, 32'd0);
            check($sformatf("v%0d tx idle after", v), ones(0, n0 + 51, n0 + 61), 32'd11);
        end

        // Three back-to-back frames.
        pb[0] = 8'h00; pb[1] = 8'hFF; pb[2] = 8'h3C;
        push_bytes(pb, 3, n0);
        tick(165);
        for (int f = 0; f < 3; f++) begin
            check_frame($sformatf("b2b f%0d", f), n0 + 1 + 50 * f, vecs[f + 1].line);
            check($sformatf("b2b end f%0d", f), {31'd0, sample(2, n0 + 51 + 50 * f)}, 32'd1);
        end
        check("b2b end pulses", ones(2, n0, n0 + 164), 32'd3);
        check("b2b busy cont",  ones(1, n0 + 1, n0 + 150), 32'd150);
        check("b2b busy off",   {31'd0, sample(1, n0 + 151)}, 32'd0);

        // Six pushes into a depth-4 FIFO: the sixth is dropped.
        for (int i = 0; i < 5; i++) pb[i] = vecs[4 + i].data;
        pb[5] = 8'h66;
        push_bytes(pb, 6, n0);
        tick(262 - 5);
        check("ovf6 full pre",  {31'd0, sample(4, n0 + 3)}, 32'd0);
        check("ovf6 full",      {31'd0, sample(4, n0 + 4)}, 32'd1);
        check("ovf6 ovf at",    {31'd0, sample(3, n0 + 5)}, 32'd1);
        check("ovf6 ovf count", ones(3, n0, n0 + 261), 32'd1);
        for (int f = 0; f < 5; f++)
            check_frame($sformatf("ovf6 f%0d", f), n0 + 1 + 50 * f, vecs[4 + f].line);
        check("ovf6 end pulses", ones(2, n0, n0 + 261), 32'd5);
        check("ovf6 busy off",   {31'd0, sample(1, n0 + 251)}, 32'd0);
        check("ovf6 tx idle",    ones(0, n0 + 251, n0 + 261), 32'd11);

        // Push while full in the same cycle as the end-of-frame pop.
        push_bytes(pb, 5, n0);
        while (cyc < n0 + 50) tick(1);
        tx_start = 1'b1; tx_data = 8'hEE;
        tick(1);
        tx_start = 1'b0;
        tick(266 - 51);
        check("pf full before", {31'd0, sample(4, n0 + 50)}, 32'd1);
        check("pf full after",  {31'd0, sample(4, n0 + 51)}, 32'd0);
        check("pf ovf at",      {31'd0, sample(3, n0 + 51)}, 32'd1);
        check("pf ovf count",   ones(3, n0, n0 + 265), 32'd1);
        check("pf not empty",   {31'd0, sample(5, n0 + 200)}, 32'd0);
        check("pf empty",       {31'd0, sample(5, n0 + 201)}, 32'd1);
        for (int f = 0; f < 4; f++)
            check_frame($sformatf("pf f%0d", f), n0 + 51 + 50 * f, vecs[5 + f].line);
        check("pf end pulses",  ones(2, n0, n0 + 265), 32'd5);
        check("pf busy off",    {31'd0, sample(1, n0 + 251)}, 32'd0);
        check("pf tx idle",     ones(0, n0 + 251, n0 + 265), 32'd15);

        // Reset during data bit 3 with two bytes still queued.
        push_bytes(pb, 3, n0);
        while (cyc < n0 + 22) tick(1);
        #2;
        reset = 1'b0;
        #1;
        check("mid rst tx",    {31'd0, tx},       32'd1);
        check("mid rst empty", {31'd0, tx_empty}, 32'd1);
        check("mid rst busy",  {31'd0, tx_busy},  32'd0);
        check("mid rst full",  {31'd0, tx_full},  32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        r0 = cyc;
        tick(121);
        check("post rst tx high", ones(0, r0 + 1, r0 + 120), 32'd120);
        check("post rst busy",    ones(1, r0 + 1, r0 + 120), 32'd0);
        check("post rst empty",   ones(5, r0 + 1, r0 + 120), 32'd120);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
